// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the serial ALU.
// Defining ALU_SLT_EN turns opcode 010 into signed set-less-than.
package alu_pkg;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_NOT = 3'b001;
    localparam logic [2:0] OP_SLT = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_AND = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Ops that run the adder with b inverted and a forced carry-in of 1.
    function automatic logic op_is_sub(input logic [2:0] op);
`ifdef ALU_SLT_EN
        return (op == OP_SUB) || (op == OP_SLT);
`else
        return (op == OP_SUB);
`endif
    endfunction

    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == OP_ADD) || op_is_sub(op);
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Purpose: one SLICE-bit step of the serial ALU (add/sub/logic).
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module alu_slice
    import alu_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    input  logic             carry_in,
    input  logic [2:0]       alop,
    output logic [SLICE-1:0] res_s,
    output logic             carry_out,
    output logic             carry_into_msb
);

    logic [SLICE-1:0] w_b;
    logic [SLICE:0]   w_sum;

    assign w_b   = op_is_sub(alop) ? ~b_s : b_s;
    assign w_sum = {1'b0, a_s} + {1'b0, w_b} + {{SLICE{1'b0}}, carry_in};

    always_comb begin
        res_s          = '0;
        carry_out      = 1'b0;
        carry_into_msb = 1'b0;
        if (op_is_arith(alop)) begin
            res_s     = w_sum[SLICE-1:0];
            carry_out = w_sum[SLICE];
            // Sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out directly.
            carry_into_msb = w_sum[SLICE-1] ^ a_s[SLICE-1] ^ w_b[SLICE-1];
        end else begin
            case (alop)
                OP_MOV:  res_s = a_s;
                OP_NOT:  res_s = ~a_s;
                OP_OR:   res_s = a_s | b_s;
                OP_AND:  res_s = a_s & b_s;
                default: res_s = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_serial.sv
// Purpose: WIDTH-bit ALU iterating a SLICE-bit datapath LSB first; ALU_SLT_EN adds SLT.
// Latency: out_valid WIDTH/SLICE cycles after the accept edge.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alop,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NS = WIDTH / SLICE;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NS - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_result;
    logic [2:0]       r_op;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_c_out, r_ovf, r_zero, r_in_ready, r_out_valid;

    logic [IW-1:0]    w_base;
    logic [SLICE-1:0] w_res_s;
    logic             w_carry_out, w_carry_into_msb, w_arith;
    logic [WIDTH-1:0] w_res_full, w_final;

    assign w_base  = IW'(int'(r_cnt) * SLICE);
    assign w_arith = (r_op == OP_ADD) || (r_op == OP_SUB);

    alu_slice #(.SLICE(SLICE)) u_slice (
        .a_s            (r_a[w_base +: SLICE]),
        .b_s            (r_b[w_base +: SLICE]),
        .carry_in       (r_carry),
        .alop           (r_op),
        .res_s          (w_res_s),
        .carry_out      (w_carry_out),
        .carry_into_msb (w_carry_into_msb)
    );

    always_comb begin
        w_res_full = r_result;
        w_res_full[w_base +: SLICE] = w_res_s;
`ifdef ALU_SLT_EN
        // On the last slice, N ^ V = msb ^ (carry into msb ^ carry out).
        if (r_op == OP_SLT)
            w_final = WIDTH'(w_res_s[SLICE-1] ^ w_carry_into_msb ^ w_carry_out);
        else
            w_final = w_res_full;
`else
        w_final = w_res_full;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= OP_MOV;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_c_out     <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_op       <= alop;
                        r_carry    <= (alop == OP_ADD) ? c_in : op_is_sub(alop);
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_carry <= w_carry_out;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_result    <= w_final;
                        r_c_out     <= w_arith & w_carry_out;
                        r_ovf       <= w_arith & (w_carry_into_msb ^ w_carry_out);
                        r_zero      <= (w_final == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_result <= w_res_full;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign c_out     = r_c_out;
    assign overflow  = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial at WIDTH=8 with SLICE=4, 2 and 8 side by side.
module tb_alu_serial;
    import alu_pkg::*;

    localparam int W  = 8;
    localparam int ND = 3;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst, in_valid, out_ready, c_in;
    logic [W-1:0]      a, b;
    logic [2:0]        alop;
    logic [ND-1:0]     o_in_ready, o_out_valid, o_c_out, o_ovf, o_zero;
    logic [ND-1:0][W-1:0] o_result;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic int slice_of(input int g);
        return (g == 0) ? 4 : ((g == 1) ? 2 : 8);
    endfunction

    for (genvar g = 0; g < ND; g++) begin : g_dut
        alu_serial #(.WIDTH(W), .SLICE((g == 0) ? 4 : ((g == 1) ? 2 : 8))) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (o_in_ready[g]),
            .a         (a),
            .b         (b),
            .alop      (alop),
            .c_in      (c_in),
            .out_valid (o_out_valid[g]),
            .out_ready (out_ready),
            .result    (o_result[g]),
            .c_out     (o_c_out[g]),
            .overflow  (o_ovf[g]),
            .zero      (o_zero[g])
        );
    end

    function automatic vec_t mk(input logic [2:0] op, input logic [W-1:0] va, vb, input logic cin,
                                input logic [W-1:0] res, input logic c, v, z);
        vec_t t;
        t.op = op; t.a = va; t.b = vb; t.cin = cin;
        t.res = res; t.c = c; t.v = v; t.z = z;
        return t;
    endfunction

    // Reference: integer arithmetic on the operand values, range-checked for overflow.
    function automatic vec_t model(input logic [2:0] op, input logic [W-1:0] va, vb, input logic cin);
        vec_t t;
        int uv, sv;
        t.op = op; t.a = va; t.b = vb; t.cin = cin;
        t.res = '0; t.c = 1'b0; t.v = 1'b0;
        case (op)
            3'b000: t.res = va;
            3'b001: t.res = ~va;
            3'b110: t.res = va | vb;
            3'b111: t.res = va & vb;
            3'b100: begin
                uv = int'(va) + int'(vb) + int'(cin);
                sv = int'($signed(va)) + int'($signed(vb)) + int'(cin);
                t.res = uv[W-1:0];
                t.c = (uv > 255);
                t.v = (sv > 127) || (sv < -128);
            end
            3'b101: begin
                uv = int'(va) - int'(vb);
                sv = int'($signed(va)) - int'($signed(vb));
                t.res = uv[W-1:0];
                t.c = (va >= vb);
                t.v = (sv > 127) || (sv < -128);
            end
`ifdef ALU_SLT_EN
            3'b010: t.res = ($signed(va) < $signed(vb)) ? 8'd1 : 8'd0;
`endif
            default: t.res = '0;
        endcase
        t.z = (t.res == '0);
        return t;
    endfunction

    task automatic chk(input string name, input int dut, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, dut, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input vec_t v);
        int lat[ND];
        a = v.a; b = v.b; alop = v.op; c_in = v.cin;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < ND; i++) lat[i] = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            tick();
            for (int i = 0; i < ND; i++)
                if (o_out_valid[i] && lat[i] == 0) lat[i] = cyc;
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
        end
        for (int i = 0; i < ND; i++) begin
            chk({tag, ".latency"}, i, lat[i], W / slice_of(i));
            chk({tag, ".result"}, i, o_result[i], v.res);
            chk({tag, ".c_out"}, i, o_c_out[i], v.c);
            chk({tag, ".overflow"}, i, o_ovf[i], v.v);
            chk({tag, ".zero"}, i, o_zero[i], v.z);
            chk({tag, ".in_ready_busy"}, i, o_in_ready[i], 1'b0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < ND; i++) begin
            chk({tag, ".in_ready_after"}, i, o_in_ready[i], 1'b1);
            chk({tag, ".out_valid_drop"}, i, o_out_valid[i], 1'b0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int i = 0; i < ND; i++) begin
            chk({tag, ".in_ready"}, i, o_in_ready[i], 1'b1);
            chk({tag, ".out_valid"}, i, o_out_valid[i], 1'b0);
            chk({tag, ".result"}, i, o_result[i], 8'h00);
            chk({tag, ".flags"}, i, {o_c_out[i], o_ovf[i], o_zero[i]}, 3'b000);
        end
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; c_in = 1'b0;
        a = '0; b = '0; alop = OP_MOV;

        tbl.push_back(mk(OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(OP_SUB, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(OP_SUB, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(OP_MOV, 8'hA5, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(OP_NOT, 8'hA5, 8'h3C, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(OP_OR,  8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(OP_AND, 8'hF0, 8'h0F, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(3'b011, 8'h12, 8'h34, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(OP_ADD, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(OP_ADD, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1));
`ifdef ALU_SLT_EN
        tbl.push_back(mk(OP_SLT, 8'h80, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(OP_SLT, 8'h01, 8'h80, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
`else
        tbl.push_back(mk(OP_SLT, 8'h80, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(OP_SLT, 8'h01, 8'h80, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
`endif

        tick(); tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();
        chk_reset_outputs("post_reset_idle");

        foreach (tbl[k]) run_op($sformatf("vec%0d", k), tbl[k]);

        for (int k = 0; k < 40; k++) begin
            logic [2:0] op;
            logic [W-1:0] ra, rb;
            logic rc;
            op = 3'($urandom_range(0, 7));
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            run_op($sformatf("rand%0d", k), model(op, ra, rb, rc));
        end

        // Backpressure: result held, in_ready low, extra in_valid ignored.
        a = 8'h10; b = 8'h20; alop = OP_ADD; c_in = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 12 && o_out_valid != {ND{1'b1}}; c++) tick();
        a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            for (int i = 0; i < ND; i++) begin
                chk("bp.out_valid", i, o_out_valid[i], 1'b1);
                chk("bp.in_ready", i, o_in_ready[i], 1'b0);
                chk("bp.result", i, o_result[i], 8'h30);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < ND; i++) begin
            chk("bp.in_ready_after", i, o_in_ready[i], 1'b1);
            chk("bp.result_hold", i, o_result[i], 8'h30);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("bp.no_ghost_op", 0, o_out_valid, '0);
        end

        // Reset pulsed one cycle while every instance is in RUN.
        a = 8'h55; b = 8'h11; alop = OP_ADD; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("abort");
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("abort.no_out_valid", 0, o_out_valid, '0);
        end
        run_op("after_abort", mk(OP_ADD, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
